// File: rtl/hq2x_scanout.sv
// Raster scanout for the 2x scaler line buffer: generates video timing, reads the
// buffer one cycle ahead and expands BGR555 to a registered RGB888 stream.
module hq2x_scanout #(
   parameter int H_ACTIVE = 512,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 64,
   parameter int H_BP     = 80,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 3,
   parameter int V_SYNC   = 4,
   parameter int V_BP     = 38,
   parameter int SYNC_POL = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        frame_available,
   input  logic [14:0] outpixel,
   output logic [9:0]  read_x,
   output logic        line_req,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b,
   output logic        locked
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = ($clog2(H_TOTAL) < 10) ? 10 : $clog2(H_TOTAL);
   localparam int VW = ($clog2(V_TOTAL) < 1) ? 1 : $clog2(V_TOTAL);
   localparam logic SYNC_ON = (SYNC_POL != 0) ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t          state_r, state_s;
   logic [HW-1:0]   hcnt_r, hcnt_s;
   logic [VW-1:0]   vcnt_r, vcnt_s;
   logic            frame_end_s, run_s;
   logic            active_s, hs_act_s, vs_act_s, line_req_s;
   logic            de1_r, hs1_r, vs1_r;
   logic            de2_r, hs2_r, vs2_r;

   function automatic logic [7:0] expand5(input logic [4:0] c);
      return {c, c[4:2]};
   endfunction

   // next-state logic; a disable in RUN only takes effect at the frame wrap
   always_comb begin
      state_s     = state_r;
      frame_end_s = (hcnt_r == HW'(H_TOTAL - 1)) && (vcnt_r == VW'(V_TOTAL - 1));
      case (state_r)
         IDLE: begin
            if (enable) state_s = WAIT;
            else        state_s = IDLE;
         end
         WAIT: begin
            if (!enable)             state_s = IDLE;
            else if (frame_available) state_s = RUN;
            else                      state_s = WAIT;
         end
         RUN: begin
            if (frame_end_s && !enable) state_s = IDLE;
            else                        state_s = RUN;
         end
         default: state_s = IDLE;
      endcase
   end

   // raster counters: zero outside RUN and on the RUN entry cycle
   always_comb begin
      hcnt_s = '0;
      vcnt_s = '0;
      if (state_r == RUN && state_s == RUN) begin
         if (hcnt_r == HW'(H_TOTAL - 1)) begin
            hcnt_s = '0;
            if (vcnt_r == VW'(V_TOTAL - 1)) vcnt_s = '0;
            else                            vcnt_s = vcnt_r + VW'(1);
         end else begin
            hcnt_s = hcnt_r + HW'(1);
            vcnt_s = vcnt_r;
         end
      end else begin
         hcnt_s = '0;
         vcnt_s = '0;
      end
   end

   // region decode of the current counter value
   always_comb begin
      run_s    = (state_r == RUN);
      active_s = run_s && (hcnt_r < HW'(H_ACTIVE)) && (vcnt_r < VW'(V_ACTIVE));
      hs_act_s = run_s && (hcnt_r >= HW'(H_ACTIVE + H_FP))
                       && (hcnt_r <  HW'(H_ACTIVE + H_FP + H_SYNC));
      vs_act_s = run_s && (vcnt_r >= VW'(V_ACTIVE + V_FP))
                       && (vcnt_r <  VW'(V_ACTIVE + V_FP + V_SYNC));
      // registered from next-cycle counters so the pulse lines up with hcnt==0
      line_req_s = (state_s == RUN) && (hcnt_s == HW'(0))
                   && (vcnt_s < VW'(V_ACTIVE)) && !vcnt_s[0];
   end

   // state, counters and counter-aligned outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= IDLE;
         hcnt_r   <= '0;
         vcnt_r   <= '0;
         locked   <= 1'b0;
         line_req <= 1'b0;
      end else begin
         state_r  <= state_s;
         hcnt_r   <= hcnt_s;
         vcnt_r   <= vcnt_s;
         locked   <= (state_s == RUN);
         line_req <= line_req_s;
      end
   end

   // three-stage video pipeline: address register, buffer read, output register
   always_ff @(posedge clk) begin
      if (reset) begin
         read_x <= 10'd0;
         de1_r  <= 1'b0;
         hs1_r  <= 1'b0;
         vs1_r  <= 1'b0;
         de2_r  <= 1'b0;
         hs2_r  <= 1'b0;
         vs2_r  <= 1'b0;
         de     <= 1'b0;
         hsync  <= ~SYNC_ON;
         vsync  <= ~SYNC_ON;
         r      <= 8'd0;
         g      <= 8'd0;
         b      <= 8'd0;
      end else begin
         read_x <= {vcnt_r[0], hcnt_r[8:0]};
         de1_r  <= active_s;
         hs1_r  <= hs_act_s;
         vs1_r  <= vs_act_s;
         de2_r  <= de1_r;
         hs2_r  <= hs1_r;
         vs2_r  <= vs1_r;
         de     <= de2_r;
         hsync  <= hs2_r ? SYNC_ON : ~SYNC_ON;
         vsync  <= vs2_r ? SYNC_ON : ~SYNC_ON;
         if (de2_r) begin
            r <= expand5(outpixel[4:0]);
            g <= expand5(outpixel[9:5]);
            b <= expand5(outpixel[14:10]);
         end else begin
            r <= 8'd0;
            g <= 8'd0;
            b <= 8'd0;
         end
      end
   end

endmodule
